branch_resolve_queue: RTL and testbench
=======================================

Name: branch_resolve_queue

Overview:
- In-order tracking queue between the fetch-side neural predictor and the execute-stage branch unit.
- At fetch, it captures each predicted control-flow instruction: PC, predicted direction and target, perceptron sum, and BST status.
- At execute, it pops the oldest entry, compares it against the resolved outcome, and produces the update strobes that train the bias, perceptron and BST tables.
- It also produces the mispredict redirect/flush toward the front end.

Parameters:
- DEPTH, 4, queue entries; power of 2, ≥2.
- PC_W, 32, PC / target width.
- SUM_W, 9, width of the signed perceptron total_weights.
- THETA, 44, training threshold on |total_weights|.
- CNT_W, 16, width of the saturating mispredict counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- enq_valid  in  1  fetch has a prediction to record.
- enq_ready  out  1  queue can accept this cycle.
- enq_pc  in  PC_W  branch PC.
- enq_taken  in  1  predicted direction.
- enq_target  in  PC_W  predicted target (BST PC_predict_o).
- enq_sum  in  SUM_W  signed total_weights.
- enq_status  in  2  BST status at prediction.
- res_valid  in  1  execute resolves the oldest branch.
- res_taken  in  1  actual direction.
- res_target  in  PC_W  actual target (ALU result).
- res_is_branch  in  1  1 = conditional branch (opcode 0x63).
- upd_valid  out  1  one-cycle strobe; update fields below valid.
- upd_pc  out  PC_W  PC of the resolved entry.
- upd_train  out  1  train bias/perceptron tables (en_2).
- upd_bst  out  1  write BST status/target (en_1).
- upd_dir  out  1  actual direction to the training logic.
- mispredict  out  1  one-cycle redirect strobe.
- redirect_pc  out  PC_W  correct next PC.
- count  out  log2(DEPTH)+1  current occupancy.
- mis_cnt  out  CNT_W  saturating mispredict count.
- underflow  out  1  sticky; res_valid arrived while empty.

Behaviour:
- Reset (rst=0, async):
  - Pointers and count are 0; the FSM enters RUN.
  - upd_*, mispredict, redirect_pc, mis_cnt and underflow are 0.
  - enq_ready is 0 while reset is asserted and 1 from the first edge after release.
- FSM states are RUN and FLUSH.
  - RUN:
    - enq_ready = (count<DEPTH).
    - Enqueue fires on enq_valid&enq_ready.
  - RUN→FLUSH on a detected mispredict.
  - FLUSH:
    - Lasts exactly 1 cycle; enq_ready=0.
    - All entries are discarded (count=0).
    - Returns to RUN unconditionally.
- Resolution (RUN, res_valid, count>0): the head is popped. Registered outputs appear the next cycle (latency 1).
  - dir_miss = enq_taken≠res_taken.
  - tgt_miss = taken∧res_taken∧(target≠res_target).
  - mis = dir_miss∨tgt_miss.
  - |sum| is computed in SUM_W+1 bits, so the most negative value gives 2^(SUM_W-1) with no overflow.
  - upd_train = res_is_branch∧(dir_miss∨|sum|≤THETA).
  - upd_bst = res_is_branch ∨ (status≠0) (allocate on new branch, deallocate on a stale entry).
  - redirect_pc = res_taken ? res_target : pc+4.
  - mispredict = mis. The FSM enters FLUSH; mis_cnt increments and saturates at all-ones.
  - upd_dir = res_taken.
- Simultaneous enqueue and resolve in RUN:
  - Both happen and count is unchanged.
  - With a full queue, enq_ready stays 0 (no same-cycle pass-through).
  - If the resolve mispredicts, the same-cycle enqueue is dropped (younger-path instruction). The push is still acknowledged to fetch, because enq_ready was high.
- res_valid while count=0:
  - Ignored; no strobes.
  - underflow is set and stays set until reset.
- res_valid during FLUSH is ignored (no pop, no strobe). underflow is not set.
- Pointer wrap: read/write pointers are modulo DEPTH; count disambiguates full from empty.
- Reset mid-operation discards all entries immediately, with no strobes emitted.

Test Plan:
- Reset, then enqueue pc=16, taken=0, sum=+10; resolve taken=0, branch=1 → next cycle:
  - upd_valid=1, upd_train=1 (|10|≤44), mispredict=0, count=0.
- Enqueue pc=20, taken=1, target=16, sum=+100; resolve taken=1, target=8 →
  - mispredict=1, redirect_pc=8, upd_train=0 (direction correct, |100|>44).
  - FLUSH for 1 cycle with enq_ready=0; mis_cnt=1.
- Fill 4 entries → enq_ready=0 and count=4.
  - Assert enq_valid and res_valid (correct) together → head popped, no push, count=3.
  - enq_ready=1 on the following cycle.
- With 2 entries, resolve the head as a mispredict while enqueueing → count=0 after FLUSH; the new entry is absent.
- Resolve with empty queue → underflow=1 (sticky), upd_valid=0.
  - Next enqueue and resolve still function normally.
- enq_sum=−256 with a direction miss → upd_train=1, no overflow.
  - Drive 65536 mispredicts → mis_cnt holds at 0xFFFF.
  - Drop rst mid-queue → count=0 and outputs=0 asynchronously.

Source files
------------

// File: rtl/branch_resolve_queue.sv
// In-order queue of fetch-time predictions; pops the oldest entry at execute,
// compares it with the resolved outcome and drives table-update and redirect strobes.
module branch_resolve_queue #(
   parameter int DEPTH = 4,
   parameter int PC_W  = 32,
   parameter int SUM_W = 9,
   parameter int THETA = 44,
   parameter int CNT_W = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enq_valid,
   output logic                     enq_ready,
   input  logic [PC_W-1:0]          enq_pc,
   input  logic                     enq_taken,
   input  logic [PC_W-1:0]          enq_target,
   input  logic [SUM_W-1:0]         enq_sum,
   input  logic [1:0]               enq_status,
   input  logic                     res_valid,
   input  logic                     res_taken,
   input  logic [PC_W-1:0]          res_target,
   input  logic                     res_is_branch,
   output logic                     upd_valid,
   output logic [PC_W-1:0]          upd_pc,
   output logic                     upd_train,
   output logic                     upd_bst,
   output logic                     upd_dir,
   output logic                     mispredict,
   output logic [PC_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]   count,
   output logic [CNT_W-1:0]         mis_cnt,
   output logic                     underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CW    = PTR_W + 1;

   localparam logic [0:0] RUN   = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
   localparam logic [SUM_W:0]   THETA_C = (SUM_W + 1)'(THETA);
   localparam logic [PC_W-1:0]  PC_STEP = PC_W'(4);

   logic [PC_W-1:0]  pc_q     [DEPTH];
   logic             taken_q  [DEPTH];
   logic [PC_W-1:0]  target_q [DEPTH];
   logic [SUM_W-1:0] sum_q    [DEPTH];
   logic [1:0]       status_q [DEPTH];

   logic [0:0]       state;
   logic             live;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic             do_push;
   logic             do_pop;
   logic             no_head;
   logic [PC_W-1:0]  h_pc;
   logic             h_taken;
   logic [PC_W-1:0]  h_target;
   logic [SUM_W-1:0] h_sum;
   logic [1:0]       h_status;
   logic             dir_miss;
   logic             tgt_miss;
   logic             mis;
   logic [SUM_W:0]   sum_ext;
   logic [SUM_W:0]   abs_sum;
   logic             train;
   logic             bst;
   logic [PC_W-1:0]  nxt_pc;

   always_comb begin
      enq_ready = live && (state == RUN) && (count < DEPTH_C);
      do_push   = enq_valid && enq_ready;
      do_pop    = (state == RUN) && res_valid && (count != '0);
      no_head   = (state == RUN) && res_valid && (count == '0);

      h_pc      = pc_q[rd_ptr];
      h_taken   = taken_q[rd_ptr];
      h_target  = target_q[rd_ptr];
      h_sum     = sum_q[rd_ptr];
      h_status  = status_q[rd_ptr];

      dir_miss  = h_taken != res_taken;
      tgt_miss  = h_taken && res_taken && (h_target != res_target);
      mis       = dir_miss || tgt_miss;

      // One extra bit so the most negative sum has a representable magnitude
      sum_ext   = {h_sum[SUM_W-1], h_sum};
      abs_sum   = sum_ext[SUM_W] ? (~sum_ext + 1'b1) : sum_ext;
      train     = res_is_branch && (dir_miss || (abs_sum <= THETA_C));
      bst       = res_is_branch || (h_status != 2'b00);
      nxt_pc    = res_taken ? res_target : (h_pc + PC_STEP);
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_q[wr_ptr]     <= enq_pc;
         taken_q[wr_ptr]  <= enq_taken;
         target_q[wr_ptr] <= enq_target;
         sum_q[wr_ptr]    <= enq_sum;
         status_q[wr_ptr] <= enq_status;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= RUN;
         live        <= 1'b0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         upd_valid   <= 1'b0;
         upd_pc      <= '0;
         upd_train   <= 1'b0;
         upd_bst     <= 1'b0;
         upd_dir     <= 1'b0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         mis_cnt     <= '0;
         underflow   <= 1'b0;
      end else begin
         live       <= 1'b1;
         upd_valid  <= do_pop;
         upd_train  <= do_pop && train;
         upd_bst    <= do_pop && bst;
         mispredict <= do_pop && mis;
         if (do_pop) begin
            upd_pc      <= h_pc;
            upd_dir     <= res_taken;
            redirect_pc <= nxt_pc;
         end
         if (no_head)
            underflow <= 1'b1;

         if (state == FLUSH) begin
            state <= RUN;
         end else if (do_pop && mis) begin
            // Wrong-path entries, including any same-cycle push, are discarded
            state  <= FLUSH;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            if (mis_cnt != '1)
               mis_cnt <= mis_cnt + CNT_W'(1);
         end else begin
            if (do_push)
               wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)
               rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_push && !do_pop)
               count <= count + CW'(1);
            else if (do_pop && !do_push)
               count <= count - CW'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Directed self-checking bench for branch_resolve_queue with hand-computed expectations.
module tb_branch_resolve_queue;

   logic        clk;
   logic        rst;
   logic        enq_valid;
   logic        enq_ready;
   logic [31:0] enq_pc;
   logic        enq_taken;
   logic [31:0] enq_target;
   logic [8:0]  enq_sum;
   logic [1:0]  enq_status;
   logic        res_valid;
   logic        res_taken;
   logic [31:0] res_target;
   logic        res_is_branch;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_train;
   logic        upd_bst;
   logic        upd_dir;
   logic        mispredict;
   logic [31:0] redirect_pc;
   logic [2:0]  count;
   logic [7:0]  mis_cnt;
   logic        underflow;

   int unsigned n_pass;
   int unsigned n_total;

   branch_resolve_queue #(
      .DEPTH(4),
      .PC_W(32),
      .SUM_W(9),
      .THETA(44),
      .CNT_W(8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enq_valid(enq_valid),
      .enq_ready(enq_ready),
      .enq_pc(enq_pc),
      .enq_taken(enq_taken),
      .enq_target(enq_target),
      .enq_sum(enq_sum),
      .enq_status(enq_status),
      .res_valid(res_valid),
      .res_taken(res_taken),
      .res_target(res_target),
      .res_is_branch(res_is_branch),
      .upd_valid(upd_valid),
      .upd_pc(upd_pc),
      .upd_train(upd_train),
      .upd_bst(upd_bst),
      .upd_dir(upd_dir),
      .mispredict(mispredict),
      .redirect_pc(redirect_pc),
      .count(count),
      .mis_cnt(mis_cnt),
      .underflow(underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish within time budget");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp)
         n_pass++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_enq(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic [8:0] sum, input logic [1:0] st);
      enq_valid  = 1'b1;
      enq_pc     = pc;
      enq_taken  = tk;
      enq_target = tgt;
      enq_sum    = sum;
      enq_status = st;
      tick();
      enq_valid  = 1'b0;
   endtask

   task automatic do_res(input logic tk, input logic [31:0] tgt, input logic br);
      res_valid     = 1'b1;
      res_taken     = tk;
      res_target    = tgt;
      res_is_branch = br;
      tick();
      res_valid     = 1'b0;
   endtask

   initial begin
      n_pass = 0;
      n_total = 0;
      rst = 1'b0;
      enq_valid = 1'b0; enq_pc = '0; enq_taken = 1'b0; enq_target = '0;
      enq_sum = '0; enq_status = '0;
      res_valid = 1'b0; res_taken = 1'b0; res_target = '0; res_is_branch = 1'b0;

      #12;
      check("rst_ready", enq_ready, 0);
      check("rst_count", count, 0);
      check("rst_upd_valid", upd_valid, 0);
      check("rst_mis_cnt", mis_cnt, 0);
      check("rst_underflow", underflow, 0);
      rst = 1'b1;
      tick();
      check("ready_after_rst", enq_ready, 1);

      // correct not-taken, small sum trains
      do_enq(32'd16, 1'b0, 32'd0, 9'd10, 2'd0);
      check("t1_count", count, 1);
      do_res(1'b0, 32'd0, 1'b1);
      check("t1_upd_valid", upd_valid, 1);
      check("t1_upd_pc", upd_pc, 16);
      check("t1_train", upd_train, 1);
      check("t1_bst", upd_bst, 1);
      check("t1_mispredict", mispredict, 0);
      check("t1_redirect", redirect_pc, 20);
      check("t1_dir", upd_dir, 0);
      check("t1_count0", count, 0);
      tick();
      check("t1_strobe_drop", upd_valid, 0);

      // taken with wrong target
      do_enq(32'd20, 1'b1, 32'd16, 9'd100, 2'd2);
      do_res(1'b1, 32'd8, 1'b1);
      check("t2_mispredict", mispredict, 1);
      check("t2_redirect", redirect_pc, 8);
      check("t2_train", upd_train, 0);
      check("t2_bst", upd_bst, 1);
      check("t2_dir", upd_dir, 1);
      check("t2_flush_ready", enq_ready, 0);
      check("t2_mis_cnt", mis_cnt, 1);
      check("t2_count", count, 0);
      tick();
      check("t2_mis_drop", mispredict, 0);
      check("t2_ready_back", enq_ready, 1);

      // fill, then push+pop while full
      for (int i = 0; i < 4; i++)
         do_enq(32'd100 + 32'(4 * i), 1'b0, 32'd0, 9'd0, 2'd0);
      check("t3_full_count", count, 4);
      check("t3_full_ready", enq_ready, 0);
      enq_valid = 1'b1; enq_pc = 32'd116; enq_taken = 1'b0;
      res_valid = 1'b1; res_taken = 1'b0; res_is_branch = 1'b1;
      tick();
      enq_valid = 1'b0; res_valid = 1'b0;
      check("t3_count3", count, 3);
      check("t3_upd_pc", upd_pc, 100);
      check("t3_ready_again", enq_ready, 1);
      for (int i = 0; i < 3; i++)
         do_res(1'b0, 32'd0, 1'b1);
      check("t3_drain_pc", upd_pc, 112);
      check("t3_drain_count", count, 0);

      // mispredict on head while pushing drops the push
      do_enq(32'd200, 1'b0, 32'd0, 9'd0, 2'd0);
      do_enq(32'd204, 1'b0, 32'd0, 9'd0, 2'd0);
      enq_valid = 1'b1; enq_pc = 32'd208; enq_taken = 1'b0;
      res_valid = 1'b1; res_taken = 1'b1; res_target = 32'd300; res_is_branch = 1'b1;
      #1;
      check("t4_ready_pre", enq_ready, 1);
      tick();
      enq_valid = 1'b0; res_valid = 1'b0;
      check("t4_mispredict", mispredict, 1);
      check("t4_redirect", redirect_pc, 300);
      check("t4_count", count, 0);
      check("t4_mis_cnt", mis_cnt, 2);
      do_res(1'b0, 32'd0, 1'b1);
      check("t4_flush_no_pop", upd_valid, 0);
      check("t4_flush_no_uflow", underflow, 0);
      check("t4_count_after", count, 0);

      // resolve on empty queue
      do_res(1'b0, 32'd0, 1'b1);
      check("t5_underflow", underflow, 1);
      check("t5_no_strobe", upd_valid, 0);
      do_enq(32'd400, 1'b1, 32'd404, 9'h1FB, 2'd0);
      do_res(1'b1, 32'd404, 1'b1);
      check("t5_upd_valid", upd_valid, 1);
      check("t5_mispredict", mispredict, 0);
      check("t5_train", upd_train, 1);
      check("t5_redirect", redirect_pc, 404);
      check("t5_uflow_sticky", underflow, 1);

      // most negative sum with direction miss
      do_enq(32'd500, 1'b1, 32'd600, 9'h100, 2'd0);
      do_res(1'b0, 32'd0, 1'b1);
      check("t6_mispredict", mispredict, 1);
      check("t6_train", upd_train, 1);
      check("t6_redirect", redirect_pc, 504);
      check("t6_mis_cnt", mis_cnt, 3);
      tick();

      // threshold boundary and BST enable
      do_enq(32'd600, 1'b0, 32'd0, 9'd44, 2'd0);
      do_res(1'b0, 32'd0, 1'b1);
      check("th_44_train", upd_train, 1);
      do_enq(32'd604, 1'b0, 32'd0, 9'd45, 2'd0);
      do_res(1'b0, 32'd0, 1'b1);
      check("th_45_train", upd_train, 0);
      do_enq(32'd608, 1'b0, 32'd0, 9'h1D3, 2'd3);
      do_res(1'b0, 32'd0, 1'b0);
      check("nb_train", upd_train, 0);
      check("stale_bst", upd_bst, 1);
      do_enq(32'd612, 1'b0, 32'd0, 9'd0, 2'd0);
      do_res(1'b0, 32'd0, 1'b0);
      check("nb_nobst", upd_bst, 0);
      check("nb_mis_cnt", mis_cnt, 3);

      // saturate the mispredict counter
      for (int i = 0; i < 260; i++) begin
         do_enq(32'd700, 1'b0, 32'd0, 9'd0, 2'd0);
         do_res(1'b1, 32'd800, 1'b1);
         tick();
      end
      check("sat_mis_cnt", mis_cnt, 8'hFF);

      // asynchronous reset mid-queue
      do_enq(32'd900, 1'b0, 32'd0, 9'd0, 2'd0);
      do_enq(32'd904, 1'b0, 32'd0, 9'd0, 2'd0);
      do_enq(32'd908, 1'b0, 32'd0, 9'd0, 2'd0);
      do_res(1'b0, 32'd0, 1'b1);
      check("pre_rst_count", count, 2);
      check("pre_rst_valid", upd_valid, 1);
      #2;
      rst = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_upd_valid", upd_valid, 0);
      check("arst_upd_pc", upd_pc, 0);
      check("arst_redirect", redirect_pc, 0);
      check("arst_mis_cnt", mis_cnt, 0);
      check("arst_underflow", underflow, 0);
      check("arst_ready", enq_ready, 0);
      rst = 1'b1;
      tick();
      check("post_rst_ready", enq_ready, 1);
      check("post_rst_count", count, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
